// File: rtl/muldiv_issue_ctrl.sv
// HI/LO multiply/divide issue controller: E-stage launch, latency timing, D-stage hazard stall.
// Optional MULDIV_STALL_CNT_EN adds a saturating stall_cycles counter output.
module muldiv_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] instr_e,
  input  logic        e_valid,
  input  logic        int_req,
  input  logic        rollback,
  output logic        start,
  output logic [1:0]  op_sel,
  output logic [1:0]  mt_we,
  output logic        hilo_we,
  output logic        busy,
  output logic        stall_d,
`ifdef MULDIV_STALL_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic [3:0]  cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] MUL_LAT4 = MUL_LAT[3:0];
  localparam logic [3:0] DIV_LAT4 = DIV_LAT[3:0];

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  function automatic logic is_muldiv(input logic [31:0] instr);
    return (instr[31:26] == 6'd0) &&
           ((instr[5:0] == F_MULT) || (instr[5:0] == F_MULTU) ||
            (instr[5:0] == F_DIV)  || (instr[5:0] == F_DIVU));
  endfunction

  function automatic logic is_md_family(input logic [31:0] instr);
    return is_muldiv(instr) ||
           ((instr[31:26] == 6'd0) &&
            ((instr[5:0] == F_MFHI) || (instr[5:0] == F_MTHI) ||
             (instr[5:0] == F_MFLO) || (instr[5:0] == F_MTLO)));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  logic [0:0] state_p1;
  logic [3:0] cnt_p1;
  logic [1:0] op_sel_p1;
  logic [3:0] lat_sel;
  logic       done;
  logic       e_is_mt;

  // Stage p0: combinational decode of E/D against the registered operation state
  assign lat_sel = op_sel_p1[1] ? DIV_LAT4 : MUL_LAT4;
  assign done    = (state_p1 == S_RUN) && (cnt_p1 == lat_sel);
  assign busy    = (state_p1 == S_RUN);

  assign start   = (state_p1 == S_IDLE) && e_valid && is_muldiv(instr_e) &&
                   !int_req && !rollback && !reset;
  // rollback kills the commit even when the count has just matched
  assign hilo_we = done && !rollback && !reset;

  assign e_is_mt = e_valid && (instr_e[31:26] == 6'd0) && !busy &&
                   !int_req && !rollback && !reset;
  assign mt_we   = e_is_mt ? {instr_e[5:0] == F_MTHI, instr_e[5:0] == F_MTLO} : 2'b00;

  assign stall_d = is_md_family(instr_d) && (busy || start);

  assign cnt     = cnt_p1;
  assign op_sel  = op_sel_p1;

  // Stage p1: operation state, cycle count and latched opcode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1  <= S_IDLE;
      cnt_p1    <= 4'd1;
      op_sel_p1 <= 2'b00;
    end else if (rollback) begin
      state_p1 <= S_IDLE;
      cnt_p1   <= 4'd1;
    end else if (start) begin
      state_p1  <= S_RUN;
      cnt_p1    <= 4'd1;
      op_sel_p1 <= instr_e[1:0];
    end else if (done) begin
      state_p1 <= S_IDLE;
      cnt_p1   <= 4'd1;
    end else if (state_p1 == S_RUN) begin
      cnt_p1 <= cnt_p1 + 4'd1;
    end
  end

`ifdef MULDIV_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
    end else if (stall_d) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end
`else
  logic [31:0] unused_sat;
  assign unused_sat = sat_inc(32'd0);
`endif

  logic unused_bits;
  assign unused_bits = ^{instr_d[25:6], instr_e[25:6]};

endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Issue and sequencing controller for the HI/LO multiply/divide unit. It sits in the E stage between the pipeline and the mult/div datapath. It decodes the E-stage instruction, launches MULT/MULTU/DIV/DIVU, and times the operation to completion. It also produces the D-stage stall for HI/LO hazards and handles interrupt and rollback cancellation.

## Interface
- `MUL_LAT`, default 5: cycles from launch to commit for MULT/MULTU (range 1–15).
- `DIV_LAT`, default 10: cycles from launch to commit for DIV/DIVU (range 1–15).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `instr_d` in 32: D-stage instruction.
- `instr_e` in 32: E-stage instruction.
- `e_valid` in 1: E-stage instruction is valid (not a bubble).
- `int_req` in 1: CP0 interrupt/exception taken this cycle.
- `rollback` in 1: CP0 cancels the in-flight HI/LO operation.
- `start` out 1: launch pulse to the datapath (combinational).
- `op_sel` out 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (registered at launch).
- `mt_we` out 2: bit1 = MTHI write, bit0 = MTLO write (combinational).
- `hilo_we` out 1: one-cycle commit pulse for the HI/LO result.
- `busy` out 1: an operation is in flight.
- `stall_d` out 1: freeze D and insert a bubble into E.
- `cnt` out 4: current cycle count (debug).

## Operation
- Decode uses Op = `instr[31:26]` = 0, with Func:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO.
  - "md-family" means any of these eight.
- FSM states:
  - IDLE → RUN on launch.
  - RUN → IDLE on commit.
  - RUN → IDLE on rollback, with no commit.
- launch (drives `start`) = state IDLE & `e_valid` & E is MULT/MULTU/DIV/DIVU & !`int_req` & !`rollback` & !`reset`.
- On launch:
  - `op_sel` is latched.
  - `cnt` is set to 1.
  - `busy` goes to 1 at the next edge.
- In RUN, `cnt` increments each cycle. At `cnt` == MUL_LAT (op_sel[1]=0) or `cnt` == DIV_LAT (op_sel[1]=1):
  - `hilo_we` = 1 for that cycle.
  - At the next edge: state IDLE, `busy` 0, `cnt` 1.
- `mt_we`:
  - Asserts when E is MTHI/MTLO & `e_valid` & !`busy` & !`int_req` & !`rollback`.
  - MTHI/MTLO in E while `busy` is prevented by `stall_d`.
- `stall_d` = D is md-family & (`busy` | `start`).
  - It holds for the last busy cycle and drops the cycle after `hilo_we`.
- `int_req` behaviour:
  - Suppresses launch and `mt_we` in the same cycle.
  - An operation already in RUN continues and commits normally.
- `rollback` behaviour:
  - Next edge: state IDLE, `busy` 0, `cnt` 1.
  - `hilo_we` is forced 0 in the rollback cycle, even if the count matches.
  - `rollback` takes priority over `int_req`, launch and commit.
- Simultaneous commit and a new md-family instruction in E: no launch that cycle, because state is still RUN. It launches the following cycle.

## Timing
- Reset values: state IDLE, `busy` 0, `cnt` 1, `op_sel` 00, `hilo_we` 0, `start` 0, `mt_we` 00, `stall_d` 0.
- Reset mid-operation aborts with no commit.
- Launch at cycle T (`start` high). `busy` is high in T+1…T+L, where L = MUL_LAT or DIV_LAT.
- `hilo_we` is high in cycle T+L. `busy` is low at T+L+1, and a new launch is possible then.
- `start`, `mt_we` and `stall_d` are combinational from the current inputs and registered state. `busy`, `cnt` and `op_sel` are registered.

## Configuration
- Macro `MULDIV_STALL_CNT_EN`.
  - Defined: adds output `stall_cycles` (out, 32 bits). It counts the cycles with `stall_d` = 1, saturates at 0xFFFFFFFF, and is cleared by `reset`.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- MULT in E at cycle 0, defaults:
  - `start` = 1 at 0, `busy` = 1 in cycles 1–5, `hilo_we` = 1 at cycle 5, `busy` = 0 at cycle 6.
  - `op_sel` = 00.
- DIVU followed by MFLO in D:
  - `op_sel` = 11.
  - `stall_d` = 1 from the launch cycle through cycle 10, and 0 at cycle 11.
  - `hilo_we` = 1 at cycle 10.
- MULTU launched, then `rollback` pulsed at cycle 3:
  - `busy` = 0 at cycle 4, `cnt` = 1.
  - No `hilo_we` pulse ever.
  - A DIV presented at cycle 4 launches with `start` = 1.
- MTHI in E with `int_req` = 1: `mt_we` = 00. With `int_req` = 0 the next cycle: `mt_we` = 10.
- MULT running and `reset` asserted at cycle 2:
  - All outputs hold their reset values from cycle 3.
  - No commit.
- With `MULDIV_STALL_CNT_EN`: a DIV with MFHI in D gives `stall_cycles` = 11 after completion.
